// File: rtl/wt_dcache_rd_arbiter.sv
// Read/write port arbiter for the write-through dcache tag/data arrays.
// Round-robin among read requesters with priority, starvation promotion and a registered response stage.
module wt_dcache_rd_arbiter #(
    parameter int unsigned NumPorts    = 3,
    parameter int unsigned TagWidth    = 44,
    parameter int unsigned IdxWidth    = 8,
    parameter int unsigned OffWidth    = 4,
    parameter int unsigned StarveLimit = 15
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumPorts-1:0]          rd_req_i,
    input  logic [NumPorts-1:0]          rd_prio_i,
    input  logic [NumPorts*TagWidth-1:0] rd_tag_i,
    input  logic [NumPorts*IdxWidth-1:0] rd_idx_i,
    input  logic [NumPorts*OffWidth-1:0] rd_off_i,
    input  logic [NumPorts-1:0]          rd_tag_only_i,
    output logic [NumPorts-1:0]          rd_ack_o,
    input  logic                         wr_cl_vld_i,
    input  logic                         wr_req_i,
    output logic                         wr_ack_o,
    output logic                         arr_rd_en_o,
    output logic [IdxWidth-1:0]          arr_idx_o,
    output logic [OffWidth-1:0]          arr_off_o,
    output logic                         arr_tag_only_o,
    output logic                         resp_vld_o,
    output logic [NumPorts-1:0]          resp_port_o,
    output logic [TagWidth-1:0]          resp_tag_o,
    output logic [OffWidth-1:0]          resp_off_o
);

    localparam int unsigned PtrWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned CntWidth = 8;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(StarveLimit);

    logic [PtrWidth-1:0] rr_ptr_reg, rr_ptr_next;
    logic [CntWidth-1:0] starve_cnt_reg [NumPorts];
    logic [CntWidth-1:0] wr_starve_cnt_reg;

    logic [TagWidth-1:0] tag_arr [NumPorts];
    logic [IdxWidth-1:0] idx_arr [NumPorts];
    logic [OffWidth-1:0] off_arr [NumPorts];

    logic [NumPorts-1:0] promoted;
    logic [NumPorts-1:0] hi_set;
    logic [NumPorts-1:0] cand;
    logic                found;
    logic [PtrWidth-1:0] win_idx;
    logic                wr_forced;
    logic                rd_grant;

    genvar gi;
    generate
        for (gi = 0; gi < NumPorts; gi++) begin : g_port
            assign tag_arr[gi]  = rd_tag_i[gi*TagWidth +: TagWidth];
            assign idx_arr[gi]  = rd_idx_i[gi*IdxWidth +: IdxWidth];
            assign off_arr[gi]  = rd_off_i[gi*OffWidth +: OffWidth];
            // A starved low-priority port competes alongside the high-priority ones.
            assign promoted[gi] = rd_req_i[gi] & ~rd_prio_i[gi] & (starve_cnt_reg[gi] == CntMax);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    starve_cnt_reg[gi] <= '0;
                end else if (!wr_cl_vld_i) begin
                    if (!rd_req_i[gi] || rd_ack_o[gi]) begin
                        starve_cnt_reg[gi] <= '0;
                    end else if (starve_cnt_reg[gi] != CntMax) begin
                        starve_cnt_reg[gi] <= starve_cnt_reg[gi] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign hi_set    = (rd_req_i & rd_prio_i) | promoted;
    assign cand      = (hi_set != '0) ? hi_set : rd_req_i;
    assign wr_forced = wr_req_i & (wr_starve_cnt_reg == CntMax);

    always_comb begin
        int unsigned p;
        p       = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            p = (32'(rr_ptr_reg) + k) % NumPorts;
            if (!found && cand[p]) begin
                found   = 1'b1;
                win_idx = PtrWidth'(p);
            end
        end
    end

    // Reset also gates grants so nothing is issued while rst_i is held.
    assign rd_grant = found & ~wr_cl_vld_i & ~wr_forced & ~rst_i;
    assign wr_ack_o = wr_req_i & ~wr_cl_vld_i & ~rd_grant & ~rst_i;

    always_comb begin
        rd_ack_o = '0;
        if (rd_grant) begin
            rd_ack_o[win_idx] = 1'b1;
        end
    end

    assign arr_rd_en_o    = rd_grant;
    assign arr_idx_o      = rd_grant ? idx_arr[win_idx] : '0;
    assign arr_off_o      = rd_grant ? off_arr[win_idx] : '0;
    assign arr_tag_only_o = rd_grant & rd_tag_only_i[win_idx];

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (rd_grant) begin
            rr_ptr_next = (win_idx == PtrWidth'(NumPorts - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_reg        <= '0;
            wr_starve_cnt_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (!wr_cl_vld_i) begin
                if (!wr_req_i || wr_ack_o) begin
                    wr_starve_cnt_reg <= '0;
                end else if (wr_starve_cnt_reg != CntMax) begin
                    wr_starve_cnt_reg <= wr_starve_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Response metadata lines up with the SRAM output one cycle after the grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_vld_o  <= 1'b0;
            resp_port_o <= '0;
            resp_tag_o  <= '0;
            resp_off_o  <= '0;
        end else begin
            resp_vld_o <= rd_grant;
            if (rd_grant) begin
                resp_port_o <= rd_ack_o;
                resp_tag_o  <= tag_arr[win_idx];
                resp_off_o  <= off_arr[win_idx];
            end
        end
    end

endmodule

// File: tb/tb_wt_dcache_rd_arbiter.sv
// Directed bench for wt_dcache_rd_arbiter: a per-cycle behavioural model compared on every
// falling edge, plus hand-computed expectations for the main scenarios.
module tb_wt_dcache_rd_arbiter;

    localparam int NP  = 3;
    localparam int TW  = 44;
    localparam int IW  = 8;
    localparam int OW  = 4;
    localparam int LIM = 15;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NP-1:0]     rd_req_i = '0;
    logic [NP-1:0]     rd_prio_i = '0;
    logic [NP*TW-1:0]  rd_tag_i = '0;
    logic [NP*IW-1:0]  rd_idx_i = '0;
    logic [NP*OW-1:0]  rd_off_i = '0;
    logic [NP-1:0]     rd_tag_only_i = '0;
    logic [NP-1:0]     rd_ack_o;
    logic              wr_cl_vld_i = 1'b0;
    logic              wr_req_i = 1'b0;
    logic              wr_ack_o;
    logic              arr_rd_en_o;
    logic [IW-1:0]     arr_idx_o;
    logic [OW-1:0]     arr_off_o;
    logic              arr_tag_only_o;
    logic              resp_vld_o;
    logic [NP-1:0]     resp_port_o;
    logic [TW-1:0]     resp_tag_o;
    logic [OW-1:0]     resp_off_o;

    wt_dcache_rd_arbiter #(
        .NumPorts(NP), .TagWidth(TW), .IdxWidth(IW), .OffWidth(OW), .StarveLimit(LIM)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_req_i(rd_req_i), .rd_prio_i(rd_prio_i), .rd_tag_i(rd_tag_i),
        .rd_idx_i(rd_idx_i), .rd_off_i(rd_off_i), .rd_tag_only_i(rd_tag_only_i),
        .rd_ack_o(rd_ack_o), .wr_cl_vld_i(wr_cl_vld_i), .wr_req_i(wr_req_i),
        .wr_ack_o(wr_ack_o), .arr_rd_en_o(arr_rd_en_o), .arr_idx_o(arr_idx_o),
        .arr_off_o(arr_off_o), .arr_tag_only_o(arr_tag_only_o),
        .resp_vld_o(resp_vld_o), .resp_port_o(resp_port_o),
        .resp_tag_o(resp_tag_o), .resp_off_o(resp_off_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: wait counts per requester, next search start, last response.
    int              m_ptr;
    int              m_wait [NP];
    int              m_wwait;
    bit              m_rv;
    logic [NP-1:0]   m_rport;
    logic [TW-1:0]   m_rtag;
    logic [OW-1:0]   m_roff;
    int              exp_w = -1;
    bit              exp_wack = 1'b0;

    function automatic void model_reset();
        m_ptr   = 0;
        m_wwait = 0;
        for (int p = 0; p < NP; p++) m_wait[p] = 0;
        m_rv    = 1'b0;
        m_rport = '0;
        m_rtag  = '0;
        m_roff  = '0;
    endfunction

    always @(negedge clk_i) begin
        bit [NP-1:0] hi;
        bit [NP-1:0] cand;
        bit          forced;
        int          p;
        logic [NP-1:0] e_ack;
        if (rst_i) model_reset();
        hi = '0;
        for (int q = 0; q < NP; q++)
            if (rd_req_i[q] && (rd_prio_i[q] || m_wait[q] >= LIM)) hi[q] = 1'b1;
        cand   = (hi != 0) ? hi : rd_req_i;
        forced = wr_req_i && (m_wwait >= LIM);
        exp_w  = -1;
        if (!rst_i && !wr_cl_vld_i && !forced) begin
            for (int k = 0; k < NP; k++) begin
                p = (m_ptr + k) % NP;
                if (exp_w < 0 && cand[p]) exp_w = p;
            end
        end
        exp_wack = !rst_i && wr_req_i && !wr_cl_vld_i && (exp_w < 0);
        if (chk_en) begin
            e_ack = '0;
            if (exp_w >= 0) e_ack[exp_w] = 1'b1;
            chk("rd_ack", rd_ack_o, e_ack);
            chk("wr_ack", wr_ack_o, exp_wack);
            chk("arr_rd_en", arr_rd_en_o, exp_w >= 0);
            chk("arr_idx", arr_idx_o, (exp_w >= 0) ? rd_idx_i[exp_w*IW +: IW] : '0);
            chk("arr_off", arr_off_o, (exp_w >= 0) ? rd_off_i[exp_w*OW +: OW] : '0);
            chk("arr_tag_only", arr_tag_only_o, (exp_w >= 0) ? rd_tag_only_i[exp_w] : 1'b0);
            chk("resp_vld", resp_vld_o, m_rv);
            chk("resp_port", resp_port_o, m_rport);
            chk("resp_tag", resp_tag_o, m_rtag);
            chk("resp_off", resp_off_o, m_roff);
        end
    end

    always @(posedge clk_i) begin
        if (rst_i) begin
            model_reset();
        end else if (wr_cl_vld_i) begin
            m_rv = 1'b0;
        end else begin
            for (int q = 0; q < NP; q++) begin
                if (!rd_req_i[q] || q == exp_w) m_wait[q] = 0;
                else if (m_wait[q] < LIM) m_wait[q]++;
            end
            if (!wr_req_i || exp_wack) m_wwait = 0;
            else if (m_wwait < LIM) m_wwait++;
            m_rv = (exp_w >= 0);
            if (exp_w >= 0) begin
                m_ptr   = (exp_w + 1) % NP;
                m_rport = '0;
                m_rport[exp_w] = 1'b1;
                m_rtag  = rd_tag_i[exp_w*TW +: TW];
                m_roff  = rd_off_i[exp_w*OW +: OW];
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_i = 1'b1;
        rd_req_i = '0;
        wr_req_i = 1'b0;
        wr_cl_vld_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic set_fields();
        for (int p = 0; p < NP; p++) begin
            rd_tag_i[p*TW +: TW] = TW'(44'h100 + p);
            rd_idx_i[p*IW +: IW] = IW'(8'h10 + p);
            rd_off_i[p*OW +: OW] = OW'(p + 1);
        end
        rd_tag_only_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_fields();
        do_reset();
        chk_en = 1'b1;
        #6;
        chk("reset_resp_vld", resp_vld_o, 0);
        chk("reset_resp_port", resp_port_o, 0);
        chk("reset_rd_ack", rd_ack_o, 0);

        // Two high-priority ports alternate.
        rd_prio_i = 3'b011;
        for (int c = 1; c <= 6; c++) begin
            step();
            rd_req_i = 3'b011;
            #6;
            chk("t1_ack", rd_ack_o, (c % 2) ? 3'b001 : 3'b010);
            $display("t1 cycle %0d ack=%b resp_vld=%b resp_port=%b", c, rd_ack_o, resp_vld_o, resp_port_o);
            if (c > 1) begin
                chk("t1_resp_vld", resp_vld_o, 1);
                chk("t1_resp_port", resp_port_o, (c % 2) ? 3'b010 : 3'b001);
            end
        end

        // Low-priority port 2 starves for 15 cycles, then is promoted.
        do_reset();
        rd_prio_i = 3'b011;
        step();
        rd_req_i = 3'b011;
        for (int c = 1; c <= 20; c++) begin
            step();
            rd_req_i = 3'b111;
            #6;
            $display("t2 cycle %0d ack=%b", c, rd_ack_o);
            if (c < 16) chk("t2_port2_denied", rd_ack_o[2], 0);
            if (c == 15) chk("t2_ack_c15", rd_ack_o, 3'b010);
            if (c == 16) chk("t2_ack_c16", rd_ack_o, 3'b100);
            if (c == 17) chk("t2_ack_c17", rd_ack_o, 3'b001);
        end

        // Refill ownership blocks everything and holds rr_ptr.
        do_reset();
        rd_prio_i = 3'b111;
        for (int c = 1; c <= 6; c++) begin
            step();
            rd_req_i = 3'b111;
            wr_cl_vld_i = (c >= 3 && c <= 5);
            #6;
            $display("t3 cycle %0d cl=%b ack=%b en=%b", c, wr_cl_vld_i, rd_ack_o, arr_rd_en_o);
            if (c >= 3 && c <= 5) begin
                chk("t3_no_ack", rd_ack_o, 0);
                chk("t3_no_en", arr_rd_en_o, 0);
            end
            if (c == 2) chk("t3_ack_c2", rd_ack_o, 3'b010);
            if (c == 6) begin
                chk("t3_ack_after", rd_ack_o, 3'b100);
                chk("t3_resp_vld", resp_vld_o, 0);
            end
        end

        // Write starves behind port 0, wins on the 16th cycle.
        do_reset();
        rd_prio_i = 3'b001;
        for (int c = 1; c <= 18; c++) begin
            step();
            rd_req_i = (c <= 17) ? 3'b001 : 3'b000;
            wr_req_i = 1'b1;
            #6;
            $display("t4 cycle %0d rd_ack=%b wr_ack=%b", c, rd_ack_o, wr_ack_o);
            if (c <= 15) chk("t4_wr_denied", wr_ack_o, 0);
            if (c == 16) begin
                chk("t4_wr_ack_c16", wr_ack_o, 1);
                chk("t4_rd_ack_c16", rd_ack_o, 0);
            end
            if (c == 17) chk("t4_rd_ack_c17", rd_ack_o, 3'b001);
            if (c == 18) chk("t4_wr_ack_idle", wr_ack_o, 1);
        end

        // Tag-only lookup on port 1, then response metadata.
        do_reset();
        wr_req_i = 1'b0;
        rd_prio_i = '0;
        rd_tag_i[1*TW +: TW] = TW'(44'hABC);
        rd_off_i[1*OW +: OW] = 4'd8;
        rd_tag_only_i = 3'b010;
        step();
        rd_req_i = 3'b010;
        #6;
        $display("t5 grant ack=%b tag_only=%b off=%0d", rd_ack_o, arr_tag_only_o, arr_off_o);
        chk("t5_tag_only", arr_tag_only_o, 1);
        chk("t5_arr_off", arr_off_o, 8);
        chk("t5_arr_idx", arr_idx_o, 8'h11);
        step();
        rd_req_i = '0;
        #6;
        $display("t5 resp vld=%b tag=%0h off=%0d", resp_vld_o, resp_tag_o, resp_off_o);
        chk("t5_resp_tag", resp_tag_o, 44'hABC);
        chk("t5_resp_off", resp_off_o, 8);
        chk("t5_resp_port", resp_port_o, 3'b010);
        chk("t5_idle_idx", arr_idx_o, 0);
        step();
        #6;
        chk("t5_resp_hold_vld", resp_vld_o, 0);
        chk("t5_resp_hold_tag", resp_tag_o, 44'hABC);
        set_fields();

        // Asynchronous reset in the cycle after a grant.
        do_reset();
        rd_prio_i = 3'b001;
        step();
        rd_req_i = 3'b001;
        step();
        chk("t6_resp_vld_pre", resp_vld_o, 1);
        rst_i = 1'b1;
        #1;
        $display("t6 async reset resp_vld=%b rd_ack=%b", resp_vld_o, rd_ack_o);
        chk("t6_resp_vld", resp_vld_o, 0);
        chk("t6_resp_port", resp_port_o, 0);
        chk("t6_rd_ack", rd_ack_o, 0);
        step();
        step();
        rst_i = 1'b0;
        #6;
        chk("t6_regrant", rd_ack_o, 3'b001);
        step();
        rd_req_i = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
